// File: rtl/cmp_red_unit.sv
// Pipelined packed compare / min-max unit with multi-beat min/max reduction.
// Ports: valid_i/ready_o beat in (a_i, b_i, op_i, signed_i, sew_i, red_i, first_i, last_i); valid_o/ready_i result out (result_o, mask_o).
module cmp_red_unit #(
  parameter  int DATA_WIDTH = 32,
  localparam int NMASK      = DATA_WIDTH / 8
) (
  input  logic                  module_clk_i,
  input  logic                  module_rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [2:0]            op_i,
  input  logic                  signed_i,
  input  logic [1:0]            sew_i,
  input  logic                  red_i,
  input  logic                  first_i,
  input  logic                  last_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [NMASK-1:0]      mask_o
);

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LT  = 3'b010;
  localparam logic [2:0] OP_LE  = 3'b011;
  localparam logic [2:0] OP_GT  = 3'b100;
  localparam logic [2:0] OP_MIN = 3'b101;
  localparam logic [2:0] OP_MAX = 3'b110;

  typedef enum logic {IDLE, ACC} st_t;

  st_t st, st_nxt;

  logic [DATA_WIDTH-1:0] acc;
  logic [2:0]            lop;
  logic                  lsgn;
  logic [1:0]            lsew;

  logic                  fire;
  logic                  is_red;
  logic                  cont;
  logic                  drop;
  logic                  emit;
  logic [2:0]            e_op;
  logic                  e_sgn;
  logic [1:0]            e_sew;
  logic [5:0]            ew;
  logic [31:0]           wm;
  logic [31:0]           sb;
  logic [DATA_WIDTH-1:0] opy;
  logic [DATA_WIDTH-1:0] ev_res;
  logic [DATA_WIDTH-1:0] fold_res;
  logic [NMASK-1:0]      ev_msk;

  assign ready_o = !valid_o || ready_i;
  assign fire    = valid_i && ready_o;
  assign is_red  = red_i && (op_i == OP_MIN || op_i == OP_MAX);
  assign cont    = is_red && !first_i && (st == ACC);
  assign drop    = is_red && !first_i && (st == IDLE);
  assign emit    = !is_red || (last_i && !drop);

  // Continuation beats run on the fields latched at the first beat.
  assign e_op  = cont ? lop  : op_i;
  assign e_sgn = cont ? lsgn : signed_i;
  assign e_sew = cont ? lsew : sew_i;
  assign opy   = cont ? acc  : b_i;

  assign ew = (e_sew == 2'b00) ? 6'd8 :
              (e_sew == 2'b01) ? 6'd16 : 6'd32;
  assign wm = (ew == 6'd32) ? '1 : ((32'd1 << ew) - 32'd1);
  // Flipping the sign bit turns a signed compare into an unsigned one.
  assign sb = e_sgn ? (32'd1 << (ew - 6'd1)) : '0;

  always_comb begin : elem
    logic [31:0] xf, yf, xb, yb, r;
    logic        lt, eq, c;
    ev_res = '0;
    ev_msk = '0;
    xf = '0;
    yf = '0;
    xb = '0;
    yb = '0;
    r  = '0;
    lt = 1'b0;
    eq = 1'b0;
    c  = 1'b0;
    for (int k = 0; k < NMASK; k++) begin
      if ((k * int'(ew)) < DATA_WIDTH) begin
        xf = 32'(a_i >> (k * int'(ew))) & wm;
        yf = 32'(opy >> (k * int'(ew))) & wm;
        xb = xf ^ sb;
        yb = yf ^ sb;
        lt = xb < yb;
        eq = xf == yf;
        case (e_op)
          OP_EQ:   c = eq;
          OP_NE:   c = !eq;
          OP_LT:   c = lt;
          OP_LE:   c = lt || eq;
          OP_GT:   c = !(lt || eq);
          default: c = 1'b0;
        endcase
        unique case (1'b1)
          (e_op == OP_MIN): r = (yb < xb) ? yf : xf;
          (e_op == OP_MAX): r = (xb < yb) ? yf : xf;
          (e_op == 3'b111): r = '0;
          default:          r = c ? wm : '0;
        endcase
        ev_res    = ev_res | (DATA_WIDTH'(r) << (k * int'(ew)));
        ev_msk[k] = c;
      end
    end
  end

  // Strict compare keeps the lower index on ties.
  always_comb begin : fold
    logic [31:0] v, best;
    best = 32'(ev_res) & wm;
    v    = '0;
    for (int k = 1; k < NMASK; k++) begin
      if ((k * int'(ew)) < DATA_WIDTH) begin
        v = 32'(ev_res >> (k * int'(ew))) & wm;
        if (e_op == OP_MAX ? ((v ^ sb) > (best ^ sb))
                           : ((v ^ sb) < (best ^ sb)))
          best = v;
      end
    end
    fold_res = DATA_WIDTH'(best);
  end

  always_ff @(posedge module_clk_i) begin
    if (module_rst_i) st <= IDLE;
    else              st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (fire && is_red && !drop)
      st_nxt = last_i ? IDLE : ACC;
  end

  always_ff @(posedge module_clk_i) begin
    if (module_rst_i) begin
      valid_o  <= 1'b0;
      result_o <= '0;
      mask_o   <= '0;
      acc      <= '0;
      lop      <= '0;
      lsgn     <= 1'b0;
      lsew     <= '0;
    end else begin
      if (valid_o && ready_i)
        valid_o <= 1'b0;
      if (fire) begin
        if (is_red && !drop)
          acc <= ev_res;
        if (is_red && first_i) begin
          lop  <= op_i;
          lsgn <= signed_i;
          lsew <= sew_i;
        end
        if (emit) begin
          valid_o  <= 1'b1;
          result_o <= is_red ? fold_res : ev_res;
          mask_o   <= is_red ? '0 : ev_msk;
        end
      end
    end
  end

endmodule
